// File: rtl/alu_issue_stage.sv
// Execute-stage front end: decodes an accepted instruction into ALU controls (S1),
// then captures the external ALU's result and flags into an output register (S2).
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int RIDX_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_opcode,
    input  logic [5:0]        in_funct,
    input  logic [DATA_W-1:0] in_rs_val,
    input  logic [DATA_W-1:0] in_rt_val,
    input  logic [15:0]       in_imm,
    input  logic [RIDX_W-1:0] in_rt_idx,
    input  logic [RIDX_W-1:0] in_rd_idx,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [RIDX_W-1:0] out_dest,
    output logic              out_branch,
    output logic              out_illegal
);

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_XORI  = 6'b001110;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_XOR = 3'b111;

    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_a_q, s1_a_d;
    logic [DATA_W-1:0] s1_b_q, s1_b_d;
    logic [2:0]        s1_op_q, s1_op_d;
    logic [RIDX_W-1:0] s1_dest_q, s1_dest_d;
    logic              s1_beq_q, s1_beq_d;
    logic              s1_illegal_q, s1_illegal_d;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_result_q, out_result_d;
    logic [RIDX_W-1:0] out_dest_q, out_dest_d;
    logic              out_branch_q, out_branch_d;
    logic              out_illegal_q, out_illegal_d;

    logic              s2_free;
    logic              s1_move;
    logic              accept;

    logic [DATA_W-1:0] dec_a, dec_b;
    logic [2:0]        dec_op;
    logic [RIDX_W-1:0] dec_dest;
    logic              dec_beq, dec_illegal;
    logic [DATA_W-1:0] imm_sext, imm_zext;

    assign s2_free  = !out_valid_q || out_ready;
    assign s1_move  = s1_valid_q && s2_free;
    assign in_ready = !s1_valid_q || s2_free;
    assign accept   = in_valid && in_ready;

    assign imm_sext = {{(DATA_W-16){in_imm[15]}}, in_imm};
    assign imm_zext = {{(DATA_W-16){1'b0}}, in_imm};

    // Unsupported encodings collapse to an all-zero ALU request flagged illegal.
    always_comb begin
        dec_a       = in_rs_val;
        dec_b       = in_rt_val;
        dec_op      = ALU_AND;
        dec_dest    = in_rd_idx;
        dec_beq     = 1'b0;
        dec_illegal = 1'b0;
        case (in_opcode)
            OPC_RTYPE: begin
                case (in_funct)
                    6'b100100: dec_op = ALU_AND;
                    6'b100101: dec_op = ALU_OR;
                    6'b100000: dec_op = ALU_ADD;
                    6'b100010: dec_op = ALU_SUB;
                    6'b100110: dec_op = ALU_XOR;
                    default:   dec_illegal = 1'b1;
                endcase
            end
            OPC_ADDI: begin dec_op = ALU_ADD; dec_b = imm_sext; dec_dest = in_rt_idx; end
            OPC_ANDI: begin dec_op = ALU_AND; dec_b = imm_zext; dec_dest = in_rt_idx; end
            OPC_ORI:  begin dec_op = ALU_OR;  dec_b = imm_zext; dec_dest = in_rt_idx; end
            OPC_XORI: begin dec_op = ALU_XOR; dec_b = imm_zext; dec_dest = in_rt_idx; end
            OPC_BEQ:  begin dec_op = ALU_SUB; dec_dest = '0; dec_beq = 1'b1; end
            default:  dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
            dec_a    = '0;
            dec_b    = '0;
            dec_op   = ALU_AND;
            dec_dest = '0;
        end
    end

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        s1_op_d      = s1_op_q;
        s1_dest_d    = s1_dest_q;
        s1_beq_d     = s1_beq_q;
        s1_illegal_d = s1_illegal_q;
        if (accept) begin
            s1_valid_d   = 1'b1;
            s1_a_d       = dec_a;
            s1_b_d       = dec_b;
            s1_op_d      = dec_op;
            s1_dest_d    = dec_dest;
            s1_beq_d     = dec_beq;
            s1_illegal_d = dec_illegal;
        end else if (s1_move) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        out_valid_d   = out_valid_q;
        out_result_d  = out_result_q;
        out_dest_d    = out_dest_q;
        out_branch_d  = out_branch_q;
        out_illegal_d = out_illegal_q;
        if (s1_move) begin
            out_valid_d   = 1'b1;
            out_result_d  = s1_illegal_q ? '0 : alu_result;
            out_dest_d    = s1_dest_q;
            out_branch_d  = s1_beq_q && alu_zero;
            out_illegal_d = s1_illegal_q;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q    <= 1'b0;
            s1_a_q        <= '0;
            s1_b_q        <= '0;
            s1_op_q       <= '0;
            s1_dest_q     <= '0;
            s1_beq_q      <= 1'b0;
            s1_illegal_q  <= 1'b0;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_dest_q    <= '0;
            out_branch_q  <= 1'b0;
            out_illegal_q <= 1'b0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_a_q        <= s1_a_d;
            s1_b_q        <= s1_b_d;
            s1_op_q       <= s1_op_d;
            s1_dest_q     <= s1_dest_d;
            s1_beq_q      <= s1_beq_d;
            s1_illegal_q  <= s1_illegal_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_dest_q    <= out_dest_d;
            out_branch_q  <= out_branch_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    assign alu_a       = s1_a_q;
    assign alu_b       = s1_b_q;
    assign alu_op      = s1_op_q;
    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_dest    = out_dest_q;
    assign out_branch  = out_branch_q;
    assign out_illegal = out_illegal_q;

endmodule
